npu_act_mem_wr_arbiter: RTL and testbench
=========================================

// Module: npu_act_mem_wr_arbiter
// PURPOSE
// Responder end of the neuron hw_mem_wr / hw_mem_wr_ack_p handshake. Collects held write
// requests from all NPU neurons, round-robin arbitrates, drives one activation-RAM write
// port per cycle and returns a one-cycle ack pulse to the served neuron. Sits between the
// neuron array and the activation buffer; also counts layer writes and flags bad addresses.
// PARAMETERS
// NUM_NEURONS  8                      number of requesting neurons (>=2)
// ADDR_WIDTH   `LOG2_ACT_ADDR_WIDTH   activation RAM address width
// DATA_WIDTH   8                      activation word width
// ACT_DEPTH    1<<ADDR_WIDTH          valid addresses 0..ACT_DEPTH-1
// PORTS
// clk          in   1                     system clock
// rst          in   1                     asynchronous reset, active-low
// req_wr       in   NUM_NEURONS           per-neuron hw_mem_wr, held high until acked
// req_addr     in   NUM_NEURONS*ADDR_WIDTH  packed hw_mem_wr_addr, neuron i at [i*AW +: AW]
// req_data     in   NUM_NEURONS*DATA_WIDTH  packed hw_mem_wr_data
// req_ack_p    out  NUM_NEURONS           per-neuron hw_mem_wr_ack_p, one-cycle pulse
// mem_stall    in   1                     RAM port borrowed elsewhere; no new grants
// mem_we       out  1                     activation RAM write enable
// mem_addr     out  ADDR_WIDTH            activation RAM address
// mem_wdata    out  DATA_WIDTH            activation RAM write data
// clr_p        in   1                     layer start: clears wr_cnt and addr_err
// wr_cnt       out  16                    writes committed since last clr_p
// addr_err     out  1                     sticky: a request addressed >= ACT_DEPTH
// BEHAVIOUR
// - Reset (rst=0, async): req_ack_p=0, mem_we=0, mem_addr=0, mem_wdata=0, wr_cnt=0,
//   addr_err=0, round-robin pointer=0 (neuron 0 highest priority first). All outputs registered.
// - Eligible set each cycle: req_wr & ~req_ack_p (neuron being acked this cycle is masked,
//   its req_wr is still high and must not be granted twice).
// - If eligible!=0 and mem_stall=0: pick first eligible index at or after pointer (wrap at
//   NUM_NEURONS-1 -> 0). Next cycle: mem_we=1, mem_addr/mem_wdata = that neuron's addr/data,
//   req_ack_p[g]=1 (same cycle as mem_we). Pointer <= g+1 (wraps).
// - Latency: req_wr rise to ack = 1 cycle when uncontended. Throughput: 1 write/cycle across
//   distinct neurons; same neuron back-to-back needs >=1 idle cycle between its requests.
// - mem_stall=1: no grant that cycle; a write already registered still completes; pointer held.
// - Out-of-range address (>=ACT_DEPTH, only possible if ACT_DEPTH < 2^ADDR_WIDTH): request is
//   acked (neuron never hangs), mem_we stays 0, addr_err set sticky, wr_cnt not incremented.
// - wr_cnt: +1 on each mem_we=1 cycle, saturates at 16'hFFFF. clr_p clears wr_cnt and
//   addr_err; clr_p coincident with a write: cleared value wins, then count resumes (result 0).
// - clr_p does not cancel pending requests or reset pointer.
// - Req dropped before ack (protocol violation): ignored if not yet granted; no ack generated.
// - At most one bit of req_ack_p high in any cycle; mem_we never high without an ack.
// STRUCTURE
// - npu_defines.vh: LOG2_ACT_ADDR_WIDTH, NPU_NUM_NEURONS, ACT_DEPTH constant.
// - Sub-module npu_rr_arbiter (eligible vector + pointer -> one-hot grant, grant_valid,
//   grant index); rest is output/counter registers in this file.
// TESTING
// - Reset: drive rst=0 mid-write with req_wr=8'hFF -> all outputs 0 immediately; after release
//   neuron 0 acked first.
// - Single request: req_wr[3]=1, addr=0x12, data=0x5A -> next cycle mem_we=1, mem_addr=0x12,
//   mem_wdata=0x5A, req_ack_p=8'h08; wr_cnt=1.
// - Contention: req_wr=8'hFF held, each neuron drops req after its ack -> acks 0,1,..,7 on 8
//   consecutive cycles, wr_cnt=8, never two acks in one cycle.
// - Fairness/wrap: pointer at 6, req_wr=8'h41 -> neuron 6 then neuron 0; re-request of 6
//   immediately after ack served only after 0.
// - Stall: mem_stall=1 for 3 cycles with req_wr[1]=1 -> no mem_we/ack during stall; ack one
//   cycle after stall drops.
// - Error/clear: ACT_DEPTH=200, req addr=250 -> ack pulse, mem_we=0, addr_err=1, wr_cnt
//   unchanged; clr_p coincident with valid write -> wr_cnt=0, addr_err=0.

Source files
------------

// File: rtl/npu_act_mem_wr_arbiter_pkg.sv
// Shared constants and helpers for the activation-RAM write arbiter slice.
// Holds the NPU-wide sizing defaults and the saturating write-counter type.
package npu_act_mem_wr_arbiter_pkg;

    localparam int LOG2_ACT_ADDR_WIDTH = 8;
    localparam int NPU_NUM_NEURONS     = 8;
    localparam int ACT_DATA_WIDTH      = 8;
    localparam int NPU_ACT_DEPTH       = 1 << LOG2_ACT_ADDR_WIDTH;
    localparam int WR_CNT_WIDTH        = 16;

    typedef logic [WR_CNT_WIDTH-1:0] wr_cnt_t;

    localparam wr_cnt_t WR_CNT_MAX = '1;

    // Counter sticks at all-ones rather than wrapping back to zero.
    function automatic wr_cnt_t wr_cnt_sat_inc(input wr_cnt_t cnt);
        return (cnt == WR_CNT_MAX) ? cnt : cnt + wr_cnt_t'(1);
    endfunction

endpackage

// File: rtl/npu_rr_arbiter.sv
// Round-robin picker: first eligible requester at or after the pointer, wrapping.
// Purely combinational; the caller owns the pointer register.
module npu_rr_arbiter #(
    parameter int NUM_REQ = 8
) (
    input  logic [NUM_REQ-1:0]         eligible,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant_oh,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int k;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        k           = 0;
        // Walk from the farthest offset inward so the closest eligible index is the last written.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (eligible[IDX_W'(k)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(k);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign grant_oh[gi] = grant_valid && (grant_idx == IDX_W'(gi));
    end

endmodule

// File: rtl/npu_act_mem_wr_arbiter.sv
// Collects held neuron write requests, grants one per cycle round-robin, drives the
// activation-RAM write port and returns a one-cycle ack to the served neuron.
module npu_act_mem_wr_arbiter
    import npu_act_mem_wr_arbiter_pkg::*;
#(
    parameter int NUM_NEURONS = NPU_NUM_NEURONS,
    parameter int ADDR_WIDTH  = LOG2_ACT_ADDR_WIDTH,
    parameter int DATA_WIDTH  = ACT_DATA_WIDTH,
    parameter int ACT_DEPTH   = 1 << ADDR_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS-1:0]            req_wr,
    input  logic [NUM_NEURONS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_NEURONS-1:0]            req_ack_p,
    input  logic                              mem_stall,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    input  logic                              clr_p,
    output logic [WR_CNT_WIDTH-1:0]           wr_cnt,
    output logic                              addr_err
);

    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(ACT_DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_NEURONS - 1);

    logic [ADDR_WIDTH-1:0]  addr_arr [NUM_NEURONS];
    logic [DATA_WIDTH-1:0]  data_arr [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] addr_ok;

    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_unpack
        assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign addr_ok[gi]  = ({1'b0, addr_arr[gi]} < DEPTH_LIM);
    end

    logic [NUM_NEURONS-1:0] ack_reg, ack_next;
    logic                   we_reg, we_next;
    logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]  wdata_reg, wdata_next;
    logic [IDX_W-1:0]       ptr_reg, ptr_next;
    wr_cnt_t                cnt_reg, cnt_next;
    logic                   err_reg, err_next;

    // A neuron sitting in its ack cycle still holds req_wr high; masking it avoids a double grant.
    logic [NUM_NEURONS-1:0] eligible;
    logic [NUM_NEURONS-1:0] grant_oh;
    logic                   grant_valid;
    logic [IDX_W-1:0]       grant_idx;

    assign eligible = req_wr & ~ack_reg;

    npu_rr_arbiter #(
        .NUM_REQ (NUM_NEURONS)
    ) u_rr_arbiter (
        .eligible    (eligible),
        .ptr         (ptr_reg),
        .grant_oh    (grant_oh),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    logic fire;
    logic commit;
    logic bad_addr;

    assign fire     = grant_valid & ~mem_stall;
    assign commit   = fire &  addr_ok[grant_idx];
    assign bad_addr = fire & ~addr_ok[grant_idx];

    always_comb begin
        ack_next   = fire ? grant_oh : '0;
        we_next    = commit;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        ptr_next   = ptr_reg;
        if (fire) begin
            addr_next  = addr_arr[grant_idx];
            wdata_next = data_arr[grant_idx];
            ptr_next   = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
        end
        // Layer clear dominates a write or error landing on the same edge.
        if (clr_p) begin
            cnt_next = '0;
            err_next = 1'b0;
        end else begin
            cnt_next = commit ? wr_cnt_sat_inc(cnt_reg) : cnt_reg;
            err_next = err_reg | bad_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            ack_reg   <= ack_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    assign req_ack_p = ack_reg;
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign wr_cnt    = cnt_reg;
    assign addr_err  = err_reg;

endmodule

// File: tb/tb_npu_act_mem_wr_arbiter.sv
// Scoreboard bench: the driver models neurons and the arbitration rules, pushing expected
// grants and counter states; a monitor pops and compares against the DUT each cycle.
module tb_npu_act_mem_wr_arbiter;

    localparam int N     = 8;
    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 200;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ack_p;
    logic            mem_stall;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            clr_p;
    logic [15:0]     wr_cnt;
    logic            addr_err;

    always #5 clk = ~clk;

    npu_act_mem_wr_arbiter #(
        .NUM_NEURONS (N),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .ACT_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ack_p (req_ack_p),
        .mem_stall (mem_stall),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .clr_p     (clr_p),
        .wr_cnt    (wr_cnt),
        .addr_err  (addr_err)
    );

    typedef struct { int idx; int addr; int data; bit ok; } txn_t;
    typedef struct { int cnt; bit err; } st_t;

    txn_t txn_q[$];
    st_t  st_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   in_reset = 1'b1;

    // Neuron-side and arbiter-level model state
    bit nreq[N];
    bit ndrop[N];
    int naddr[N];
    int ndata[N];
    int next_addr[N];
    int next_data[N];
    int m_ptr = 0;
    int m_last = -1;
    int m_cnt = 0;
    bit m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_pins();
        for (int i = 0; i < N; i++) begin
            req_wr[i]             = nreq[i];
            req_addr[i*AW +: AW]  = AW'(naddr[i]);
            req_data[i*DW +: DW]  = DW'(ndata[i]);
        end
    endtask

    // One clock of stimulus; entered and left just after a falling edge.
    task automatic cycle(input logic [N-1:0] want, input bit stall, input bit clr);
        int g;
        bit ok;
        for (int i = 0; i < N; i++) begin
            if (m_last == i) begin
                ndrop[i] = 1'b1;
            end else if (ndrop[i]) begin
                nreq[i]  = 1'b0;
                ndrop[i] = 1'b0;
            end else if (!nreq[i] && want[i]) begin
                nreq[i]  = 1'b1;
                naddr[i] = next_addr[i];
                ndata[i] = next_data[i];
            end
        end
        mem_stall = stall;
        clr_p     = clr;
        drive_pins();

        g  = -1;
        ok = 1'b0;
        if (!stall) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (nreq[j] && j != m_last) begin
                    g = j;
                    break;
                end
            end
        end
        if (g >= 0) begin
            ok = (naddr[g] < DEPTH);
            txn_q.push_back('{g, naddr[g], ndata[g], ok});
            m_ptr = (g + 1) % N;
        end
        if (clr) begin
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            if (g >= 0 && ok && m_cnt < 65535) m_cnt++;
            if (g >= 0 && !ok) m_err = 1'b1;
        end
        st_q.push_back('{m_cnt, m_err});
        m_last = g;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [N-1:0] hold);
        rst = 1'b0;
        #1;
        chk("rst_ack", 32'(req_ack_p), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_cnt", 32'(wr_cnt), 0);
        chk("rst_err", 32'(addr_err), 0);
        in_reset = 1'b1;
        txn_q.delete();
        st_q.delete();
        m_ptr  = 0;
        m_last = -1;
        m_cnt  = 0;
        m_err  = 1'b0;
        for (int i = 0; i < N; i++) begin
            ndrop[i] = 1'b0;
            if (hold[i] && !nreq[i]) begin
                nreq[i]  = 1'b1;
                naddr[i] = next_addr[i];
                ndata[i] = next_data[i];
            end
        end
        drive_pins();
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        in_reset = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (!in_reset) begin
            if (st_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL status_underflow: no expectation queued at %0t", $time);
            end else begin
                st_t s;
                s = st_q.pop_front();
                chk("wr_cnt", 32'(wr_cnt), 32'(s.cnt));
                chk("addr_err", 32'(addr_err), 32'(s.err));
            end
            if (req_ack_p != '0) begin
                if (txn_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ack: got 0x%0h expected none at %0t", req_ack_p, $time);
                end else begin
                    txn_t t;
                    t = txn_q.pop_front();
                    chk("ack", 32'(req_ack_p), 32'(1) << t.idx);
                    chk("mem_we", 32'(mem_we), 32'(t.ok));
                    if (t.ok) begin
                        chk("mem_addr", 32'(mem_addr), 32'(t.addr));
                        chk("mem_wdata", 32'(mem_wdata), 32'(t.data));
                    end
                end
            end else begin
                chk("we_without_ack", 32'(mem_we), 0);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        mem_stall = 1'b0;
        clr_p     = 1'b0;
        req_wr    = '0;
        req_addr  = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            nreq[i]      = 1'b0;
            ndrop[i]     = 1'b0;
            naddr[i]     = 0;
            ndata[i]     = 0;
            next_addr[i] = i * 20;
            next_data[i] = i * 3 + 7;
        end
        #2;
        do_reset('0);

        // Single request
        next_addr[3] = 8'h12;
        next_data[3] = 8'h5A;
        cycle(8'h08, 1'b0, 1'b0);
        repeat (3) cycle('0, 1'b0, 1'b0);

        // Full contention
        cycle(8'hFF, 1'b0, 1'b0);
        repeat (10) cycle('0, 1'b0, 1'b0);

        // Move pointer to 6, then 6 and 0 together, with 6 re-requesting early
        next_addr[5] = 5;
        cycle(8'h20, 1'b0, 1'b0);
        repeat (3) cycle('0, 1'b0, 1'b0);
        cycle(8'h41, 1'b0, 1'b0);
        repeat (4) cycle(8'h40, 1'b0, 1'b0);
        repeat (4) cycle('0, 1'b0, 1'b0);

        // Stall for three cycles
        cycle(8'h02, 1'b1, 1'b0);
        cycle('0, 1'b1, 1'b0);
        cycle('0, 1'b1, 1'b0);
        repeat (4) cycle('0, 1'b0, 1'b0);

        // Out-of-range address, then clear coincident with a valid write
        next_addr[2] = 250;
        cycle(8'h04, 1'b0, 1'b0);
        repeat (3) cycle('0, 1'b0, 1'b0);
        next_addr[1] = 10;
        cycle(8'h02, 1'b0, 1'b1);
        repeat (3) cycle('0, 1'b0, 1'b0);

        // Reset while a write is on the port, all neurons holding requests
        cycle(8'hFF, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0);
        do_reset(8'hFF);
        repeat (12) cycle('0, 1'b0, 1'b0);

        // Randomized traffic
        for (int r = 0; r < 3000; r++) begin
            for (int i = 0; i < N; i++) begin
                next_addr[i] = int'($urandom_range(0, 255));
                next_data[i] = int'($urandom_range(0, 255));
            end
            cycle(N'($urandom & $urandom), ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 3));
            if (r == 1500) begin
                do_reset(N'($urandom));
            end
        end
        repeat (20) cycle('0, 1'b0, 1'b0);

        chk("pending_grants", 32'(txn_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
